// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared types and constants for the TM1638 responder.
//   tm_state_e   - responder FSM state encoding
//   CMD_*        - command class, byte[7:6]
//   BIT_*        - bit positions inside command bytes
//   KEY_W        - key-scan word width
package tm1638_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4
  } tm_state_e;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int BIT_READ    = 1;  // data command: 1 = key read
  localparam int BIT_FIXED   = 2;  // data command: 1 = fixed address
  localparam int BIT_DISP_ON = 3;  // display control: display on

  localparam int KEY_W = 32;
endpackage

// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if: STB/CLK/DIO link between an initiator and the responder.
//   i_SPI_Stb    - frame strobe, active low (initiator -> responder)
//   i_SPI_Clk    - SPI clock, idle high (initiator -> responder)
//   i_SPI_Dio    - serial data, LSB first (initiator -> responder)
//   o_SPI_Dio    - serial read data (responder -> initiator)
//   o_SPI_Dio_En - responder drive enable for the external DIO tristate
interface tm1638_responder_if;
  logic i_SPI_Stb;
  logic i_SPI_Clk;
  logic i_SPI_Dio;
  logic o_SPI_Dio;
  logic o_SPI_Dio_En;

  modport master (output i_SPI_Stb, i_SPI_Clk, i_SPI_Dio,
                  input  o_SPI_Dio, o_SPI_Dio_En);
  modport slave  (input  i_SPI_Stb, i_SPI_Clk, i_SPI_Dio,
                  output o_SPI_Dio, o_SPI_Dio_En);
endinterface

// File: rtl/tm1638_pin_sync.sv
// tm1638_pin_sync: SYNC_STAGES-deep synchronizer for one asynchronous pin,
// plus single-cycle rise/fall pulses taken from the last two synced samples.
//   i_Clk, i_Rst_n - system clock, async active-low reset
//   i_Pin          - asynchronous input
//   o_Level        - synchronized level
//   o_Rise/o_Fall  - one-cycle edge pulses
module tm1638_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Pin,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);
  logic [SYNC_STAGES-1:0] r_Sync;
  logic                   r_Prev;

  // Reset to the idle level so no edge is seen when reset releases.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Sync <= {SYNC_STAGES{RST_VAL}};
      r_Prev <= RST_VAL;
    end else begin
      r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Pin};
      r_Prev <= r_Sync[SYNC_STAGES-1];
    end
  end

  assign o_Level = r_Sync[SYNC_STAGES-1];
  assign o_Rise  =  r_Sync[SYNC_STAGES-1] & ~r_Prev;
  assign o_Fall  = ~r_Sync[SYNC_STAGES-1] &  r_Prev;
endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 target emulator. Decodes data/address/display
// commands from the STB/CLK/DIO link, holds the display RAM and returns the
// key-scan word on DIO for read commands.
//   i_Clk, i_Rst_n  - system clock (>= 4x SPI clock), async active-low reset
//   spi             - STB/CLK/DIO link (slave side)
//   i_Keys          - key-scan word, bit0 sent first
//   i_Ram_Addr      - display RAM read address
//   o_Ram_Data      - registered RAM read data (1 cycle latency)
//   o_Display_On    - display on flag
//   o_Brightness    - brightness level
//   o_Frame_Err     - one-cycle pulse on a malformed frame
// Optional macro TM1638_RESP_STATS_EN adds o_Stat_Frames, o_Stat_Bytes and
// o_Stat_Errs saturating counters.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RAM_DEPTH   = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  tm1638_responder_if.slave spi,
  input  logic [KEY_W-1:0] i_Keys,
  input  logic [3:0]       i_Ram_Addr,
  output logic [7:0]       o_Ram_Data,
  output logic             o_Display_On,
  output logic [2:0]       o_Brightness,
  output logic             o_Frame_Err
`ifdef TM1638_RESP_STATS_EN
  ,
  output logic [15:0]      o_Stat_Frames,
  output logic [15:0]      o_Stat_Bytes,
  output logic [7:0]       o_Stat_Errs
`endif
);
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_CMD   = S_CMD;
  localparam logic [2:0] ST_WRITE = S_WRITE;
  localparam logic [2:0] ST_READ  = S_READ;
  localparam logic [2:0] ST_DRAIN = S_DRAIN;

  // Pin index: 2 = STB, 1 = CLK, 0 = DIO.
  logic [2:0] w_Lvl, w_Rise, w_Fall;

  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync [2:0] (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Pin   ({spi.i_SPI_Stb, spi.i_SPI_Clk, spi.i_SPI_Dio}),
    .o_Level (w_Lvl),
    .o_Rise  (w_Rise),
    .o_Fall  (w_Fall)
  );

  logic [2:0]       r_State;
  logic [2:0]       r_Cnt;
  logic [6:0]       r_Shift;
  logic [3:0]       r_Ptr;
  logic             r_Fixed;
  logic [KEY_W-1:0] r_KeySh;
  logic [4:0]       r_BitCnt;
  logic             r_Dio, r_Dio_En;
  logic             r_Disp;
  logic [2:0]       r_Bright;
  logic             r_Err;
  logic [7:0]       r_Ram [RAM_DEPTH];

  logic       w_StbRise, w_StbFall, w_ClkRise, w_ClkFall, w_Bit;
  logic [7:0] w_Byte;
  logic       w_ByteDone, w_CmdErr, w_StbErr, w_Err, w_RamWe;
  logic [3:0] w_PtrNext;

  assign w_StbRise = w_Rise[2];
  assign w_StbFall = w_Fall[2];
  assign w_ClkRise = w_Rise[1];
  assign w_ClkFall = w_Fall[1];
  assign w_Bit     = w_Lvl[0];
  // Valid only when the 8th bit is arriving: bits 0..6 are already held.
  assign w_Byte    = {w_Bit, r_Shift};

  // STB rise has priority: a coincident CLK rise never completes a byte.
  assign w_ByteDone = ~w_StbRise & w_ClkRise & (r_Cnt == 3'd7) &
                      ((r_State == ST_CMD) || (r_State == ST_WRITE));
  assign w_CmdErr   = w_ByteDone & (r_State == ST_CMD) & (w_Byte[7:6] == 2'b00);
  // Any STB rise in READ is early: 32 bits done moves the FSM to DRAIN.
  assign w_StbErr   = w_StbRise &
                      ((((r_State == ST_CMD) || (r_State == ST_WRITE)) && (r_Cnt != 3'd0)) ||
                       (r_State == ST_READ));
  assign w_Err      = w_CmdErr | w_StbErr;
  assign w_RamWe    = w_ByteDone & (r_State == ST_WRITE);
  assign w_PtrNext  = (r_Ptr == 4'(RAM_DEPTH-1)) ? 4'd0 : r_Ptr + 4'd1;

  logic w_unused;
  assign w_unused = ^{w_Byte[5:4], w_Lvl[2:1], w_Rise[0], w_Fall[0]};

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State  <= ST_IDLE;
      r_Cnt    <= '0;
      r_Shift  <= '0;
      r_Ptr    <= '0;
      r_Fixed  <= 1'b0;
      r_KeySh  <= '0;
      r_BitCnt <= '0;
      r_Dio    <= 1'b1;
      r_Dio_En <= 1'b0;
      r_Disp   <= 1'b0;
      r_Bright <= '0;
      r_Err    <= 1'b0;
    end else begin
      r_Err <= w_Err;
      if (w_StbRise) begin
        r_State  <= ST_IDLE;
        r_Cnt    <= '0;
        r_Dio    <= 1'b1;
        r_Dio_En <= 1'b0;
      end else begin
        case (r_State)
          ST_IDLE: if (w_StbFall) begin
            r_State <= ST_CMD;
            r_Cnt   <= '0;
          end
          ST_CMD, ST_WRITE: if (w_ClkRise) begin
            if (r_Cnt != 3'd7) r_Shift[r_Cnt] <= w_Bit;
            r_Cnt <= r_Cnt + 3'd1;
            if (r_Cnt == 3'd7) begin
              if (r_State == ST_WRITE) begin
                if (!r_Fixed) r_Ptr <= w_PtrNext;
              end else begin
                case (w_Byte[7:6])
                  CMD_DATA: begin
                    r_Fixed <= w_Byte[BIT_FIXED];
                    if (w_Byte[BIT_READ]) begin
                      r_State  <= ST_READ;
                      r_KeySh  <= i_Keys;
                      r_BitCnt <= '0;
                      r_Dio_En <= 1'b1;
                    end else begin
                      r_State <= ST_DRAIN;
                    end
                  end
                  CMD_DISP: begin
                    r_Disp   <= w_Byte[BIT_DISP_ON];
                    r_Bright <= w_Byte[2:0];
                    r_State  <= ST_DRAIN;
                  end
                  CMD_ADDR: begin
                    r_Ptr   <= w_Byte[3:0];
                    r_State <= ST_WRITE;
                  end
                  default: r_State <= ST_DRAIN;
                endcase
              end
            end
          end
          ST_READ: begin
            if (w_ClkFall) begin
              r_Dio   <= r_KeySh[0];
              r_KeySh <= {1'b0, r_KeySh[KEY_W-1:1]};
            end
            if (w_ClkRise) begin
              r_BitCnt <= r_BitCnt + 5'd1;
              if (r_BitCnt == 5'd31) begin
                r_Dio_En <= 1'b0;
                r_Dio    <= 1'b1;
                r_State  <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: ;
          default: r_State <= ST_IDLE;
        endcase
      end
    end
  end

  // Single write port from the FSM, single registered read port; a
  // same-address read in the write cycle returns the old byte.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) r_Ram[i] <= '0;
      o_Ram_Data <= '0;
    end else begin
      if (w_RamWe) r_Ram[r_Ptr] <= w_Byte;
      o_Ram_Data <= r_Ram[i_Ram_Addr];
    end
  end

  assign spi.o_SPI_Dio    = r_Dio;
  assign spi.o_SPI_Dio_En = r_Dio_En;
  assign o_Display_On     = r_Disp;
  assign o_Brightness     = r_Bright;
  assign o_Frame_Err      = r_Err;

`ifdef TM1638_RESP_STATS_EN
  logic [15:0] r_StFrames, r_StBytes;
  logic [7:0]  r_StErrs;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_StFrames <= '0;
      r_StBytes  <= '0;
      r_StErrs   <= '0;
    end else begin
      if (w_StbRise  && !(&r_StFrames)) r_StFrames <= r_StFrames + 16'd1;
      if (w_ByteDone && !(&r_StBytes))  r_StBytes  <= r_StBytes  + 16'd1;
      if (w_Err      && !(&r_StErrs))   r_StErrs   <= r_StErrs   + 8'd1;
    end
  end

  assign o_Stat_Frames = r_StFrames;
  assign o_Stat_Bytes  = r_StBytes;
  assign o_Stat_Errs   = r_StErrs;
`endif
endmodule

// File: tb/tb_tm1638_responder.sv
module tb_tm1638_responder;
  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic [31:0] i_Keys = '0;
  logic [3:0]  i_Ram_Addr = '0;
  logic [7:0]  o_Ram_Data;
  logic        o_Display_On;
  logic [2:0]  o_Brightness;
  logic        o_Frame_Err;
`ifdef TM1638_RESP_STATS_EN
  logic [15:0] o_Stat_Frames, o_Stat_Bytes;
  logic [7:0]  o_Stat_Errs;
`endif

  tm1638_responder_if spi_if();

  tm1638_responder #(.SYNC_STAGES(2), .RAM_DEPTH(16)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .spi          (spi_if),
    .i_Keys       (i_Keys),
    .i_Ram_Addr   (i_Ram_Addr),
    .o_Ram_Data   (o_Ram_Data),
    .o_Display_On (o_Display_On),
    .o_Brightness (o_Brightness),
    .o_Frame_Err  (o_Frame_Err)
`ifdef TM1638_RESP_STATS_EN
    ,
    .o_Stat_Frames(o_Stat_Frames),
    .o_Stat_Bytes (o_Stat_Bytes),
    .o_Stat_Errs  (o_Stat_Errs)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        q_exp [$];
  logic [31:0] q_act [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          err_seen = 0;

  // Count o_Frame_Err pulses as the DUT presents them.
  always @(negedge i_Clk) if (o_Frame_Err) err_seen++;

  // Scoreboard monitor: pops expected/observed pairs and compares.
  always @(negedge i_Clk) begin
    while (q_act.size() > 0 && q_exp.size() > 0) begin
      exp_t        e;
      logic [31:0] a;
      e = q_exp.pop_front();
      a = q_act.pop_front();
      n_checks++;
      if (a !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
      end
    end
  end

  task automatic post(input string n, input logic [31:0] e, input logic [31:0] a);
    q_exp.push_back('{n, e});
    q_act.push_back(a);
  endtask

  task automatic phase();
    repeat (4) @(negedge i_Clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_if.i_SPI_Clk = 1'b0;
      spi_if.i_SPI_Dio = b[i];
      phase();
      spi_if.i_SPI_Clk = 1'b1;
      phase();
    end
  endtask

  task automatic start();
    spi_if.i_SPI_Stb = 1'b0;
    phase();
  endtask

  task automatic stop();
    spi_if.i_SPI_Stb = 1'b1;
    phase();
    phase();
  endtask

  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    start();
    for (int i = 0; i < n; i++) send_bits(bs[i], 8);
    stop();
  endtask

  // Initiator samples just before each rising edge.
  task automatic read_bits(input int n, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      spi_if.i_SPI_Clk = 1'b0;
      phase();
      w[i] = spi_if.o_SPI_Dio;
      spi_if.i_SPI_Clk = 1'b1;
      phase();
    end
  endtask

  task automatic chk_ram(input logic [3:0] a, input logic [7:0] e, input string n);
    @(negedge i_Clk);
    i_Ram_Addr = a;
    @(negedge i_Clk);
    post(n, {24'd0, e}, {24'd0, o_Ram_Data});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int e0;
    spi_if.i_SPI_Stb = 1'b1;
    spi_if.i_SPI_Clk = 1'b1;
    spi_if.i_SPI_Dio = 1'b1;
    repeat (3) @(negedge i_Clk);
    post("rst_dio_en", 0, {31'd0, spi_if.o_SPI_Dio_En});
    post("rst_dio",    1, {31'd0, spi_if.o_SPI_Dio});
    i_Rst_n = 1'b1;
    repeat (3) @(negedge i_Clk);
    post("rst_disp",   0, {31'd0, o_Display_On});
    post("rst_bright", 0, {29'd0, o_Brightness});
    post("rst_err",    0, {31'd0, o_Frame_Err});
    chk_ram(4'd5, 8'h00, "rst_ram5");

    // Auto-increment writes
    e0 = err_seen;
    send_frame(1, 8'h40, 8'h00, 8'h00, 8'h00);
    send_frame(4, 8'hC0, 8'h11, 8'h22, 8'h33);
    chk_ram(4'd0, 8'h11, "auto_ram0");
    chk_ram(4'd1, 8'h22, "auto_ram1");
    chk_ram(4'd2, 8'h33, "auto_ram2");
    chk_ram(4'd3, 8'h00, "auto_ram3");
    post("auto_err", 0, err_seen - e0);

    // Fixed address: both bytes land on 15, nothing wraps to 0
    send_frame(1, 8'h44, 8'h00, 8'h00, 8'h00);
    send_frame(3, 8'hCF, 8'hAA, 8'hBB, 8'h00);
    chk_ram(4'd15, 8'hBB, "fixed_ram15");
    chk_ram(4'd0,  8'h11, "fixed_ram0");

    // Wrap-around in auto-increment
    send_frame(1, 8'h40, 8'h00, 8'h00, 8'h00);
    send_frame(4, 8'hCE, 8'h01, 8'h02, 8'h03);
    chk_ram(4'd14, 8'h01, "wrap_ram14");
    chk_ram(4'd15, 8'h02, "wrap_ram15");
    chk_ram(4'd0,  8'h03, "wrap_ram0");
    chk_ram(4'd1,  8'h22, "wrap_ram1");

    // Display control
    send_frame(1, 8'h8D, 8'h00, 8'h00, 8'h00);
    post("disp_on",  1, {31'd0, o_Display_On});
    post("disp_br5", 5, {29'd0, o_Brightness});
    send_frame(1, 8'h80, 8'h00, 8'h00, 8'h00);
    post("disp_off", 0, {31'd0, o_Display_On});
    post("disp_br0", 0, {29'd0, o_Brightness});

    // Full 32-bit key read
    i_Keys = 32'hA5C3_0F01;
    e0 = err_seen;
    start();
    send_bits(8'h42, 8);
    post("rd_en_on", 1, {31'd0, spi_if.o_SPI_Dio_En});
    read_bits(32, w);
    post("rd_word", 32'hA5C3_0F01, w);
    post("rd_en_off", 0, {31'd0, spi_if.o_SPI_Dio_En});
    stop();
    post("rd_err", 0, err_seen - e0);

    // Early release after 20 read bits
    i_Keys = 32'h1234_5678;
    e0 = err_seen;
    start();
    send_bits(8'h42, 8);
    read_bits(20, w);
    post("early_word", 32'h0004_5678, w);
    stop();
    post("early_err", 1, err_seen - e0);
    post("early_en",  0, {31'd0, spi_if.o_SPI_Dio_En});
    post("early_dio", 1, {31'd0, spi_if.o_SPI_Dio});

    // Partial write byte
    e0 = err_seen;
    start();
    send_bits(8'hC0, 8);
    send_bits(8'hFF, 5);
    stop();
    post("part_err", 1, err_seen - e0);
    chk_ram(4'd0, 8'h03, "part_ram0");

    // Command class 00
    e0 = err_seen;
    send_frame(2, 8'h3F, 8'h8F, 8'h00, 8'h00);
    post("bad_err",  1, err_seen - e0);
    post("bad_disp", 0, {31'd0, o_Display_On});
    chk_ram(4'd15, 8'h02, "bad_ram15");

    // Reset mid-read
    i_Keys = 32'hFFFF_FFFF;
    start();
    send_bits(8'h42, 8);
    read_bits(10, w);
    post("mid_en_pre", 1, {31'd0, spi_if.o_SPI_Dio_En});
    #1;
    i_Rst_n = 1'b0;
    #1;
    post("mid_en_rst", 0, {31'd0, spi_if.o_SPI_Dio_En});
    post("mid_dio_rst", 1, {31'd0, spi_if.o_SPI_Dio});
    spi_if.i_SPI_Stb = 1'b1;
    spi_if.i_SPI_Clk = 1'b1;
    repeat (3) @(negedge i_Clk);
    i_Rst_n = 1'b1;
    repeat (3) @(negedge i_Clk);
    chk_ram(4'd0,  8'h00, "mid_ram0");
    chk_ram(4'd15, 8'h00, "mid_ram15");

    repeat (4) @(negedge i_Clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
